// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: match state encoding and screen geometry.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_WON   = 3'd4,
    ST_OVER  = 3'd5
  } game_state_t;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_controller_frame_tick_gen.sv
// One-cycle frame tick on the first pixel clock where the scan enters line LINE.
module frame_tick_gen #(
  parameter int unsigned Y_W  = 10,
  parameter int unsigned LINE = 480
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [Y_W-1:0] i_next_y,
  output logic           o_frame_tick_c
);

  logic w_at_line;
  logic r_at_line_q;

  assign w_at_line = (i_next_y == Y_W'(LINE));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_at_line_q <= 1'b0;
    end else begin
      r_at_line_q <= w_at_line;
    end
  end

  // The line is held for a whole scan row; only its first cycle ticks.
  assign o_frame_tick_c = w_at_line & ~r_at_line_q;

endmodule

// File: rtl/game_controller.sv
// Breakout match sequencer: serve/play/life-lost/won/over flow, lives and ball gating.
module game_controller #(
  parameter int unsigned N_BLOCKS     = 10,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned LOST_FRAMES  = 90,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned V_ACTIVE     = breakout_pkg::V_ACTIVE
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic [9:0]                        i_next_x,
  input  logic [9:0]                        i_next_y,
  input  logic                              i_ball_lost,
  input  logic [N_BLOCKS-1:0]               i_block_exist,
  output logic                              o_ball_hold,
  output logic                              o_ball_run,
  output logic                              o_blocks_restore,
  output logic                              o_score_clear,
  output logic [$clog2(LIVES_INIT+1)-1:0]   o_lives,
  output logic [2:0]                        o_game_state,
  output logic                              o_flash,
  output logic                              o_game_won,
  output logic                              o_game_over
);

  import breakout_pkg::*;

  localparam int unsigned LIVES_W = $clog2(LIVES_INIT + 1);
  localparam int unsigned CNT_W   = $clog2(max_u(SERVE_FRAMES, LOST_FRAMES) + 1);
  localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);

  game_state_t        r_state, w_state_next;
  logic [LIVES_W-1:0] r_lives, w_lives_next;
  logic [CNT_W-1:0]   r_frame_cnt, w_cnt_next;
  logic [FLASH_W-1:0] r_flash_cnt, w_flash_cnt_next;
  logic               r_flash, w_flash_next;
  logic               r_start_q;
  logic               r_ball_hold, r_ball_run, r_restore, r_clear, r_won, r_over;
  logic               w_restore_next, w_clear_next;
  logic               w_start_edge;
  logic               w_frame_tick;
  logic               w_unused_hblank;

  // Horizontal scan position is not needed for sequencing.
  assign w_unused_hblank = (i_next_x >= 10'(H_ACTIVE));

  frame_tick_gen #(
    .Y_W  (10),
    .LINE (V_ACTIVE)
  ) u_frame_tick (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_next_y       (i_next_y),
    .o_frame_tick_c (w_frame_tick)
  );

  assign w_start_edge = i_start & ~r_start_q;

  // Next-state, lives, timers and pulse requests.
  always_comb begin
    w_state_next     = r_state;
    w_lives_next     = r_lives;
    w_cnt_next       = r_frame_cnt;
    w_flash_next     = r_flash;
    w_flash_cnt_next = r_flash_cnt;
    w_restore_next   = 1'b0;
    w_clear_next     = 1'b0;
    case (r_state)
      ST_IDLE, ST_WON, ST_OVER: begin
        if (w_start_edge) begin
          w_state_next     = ST_SERVE;
          w_lives_next     = LIVES_W'(LIVES_INIT);
          w_cnt_next       = '0;
          w_flash_next     = 1'b0;
          w_flash_cnt_next = '0;
          w_restore_next   = 1'b1;
          w_clear_next     = 1'b1;
        end
      end
      ST_SERVE: begin
        if (w_frame_tick) begin
          if (r_frame_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            w_state_next = ST_PLAY;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // Clearing the last block beats losing the ball in the same cycle.
        if (i_block_exist == '0) begin
          w_state_next = ST_WON;
        end else if (i_ball_lost) begin
          if (r_lives <= LIVES_W'(1)) begin
            w_state_next = ST_OVER;
            w_lives_next = '0;
          end else begin
            w_state_next     = ST_LOST;
            w_lives_next     = r_lives - LIVES_W'(1);
            w_cnt_next       = '0;
            w_flash_next     = 1'b1;
            w_flash_cnt_next = '0;
          end
        end
      end
      ST_LOST: begin
        if (w_frame_tick) begin
          if (r_frame_cnt == CNT_W'(LOST_FRAMES - 1)) begin
            w_state_next     = ST_SERVE;
            w_cnt_next       = '0;
            w_flash_next     = 1'b0;
            w_flash_cnt_next = '0;
          end else begin
            w_cnt_next = r_frame_cnt + CNT_W'(1);
            if (r_flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
              w_flash_next     = ~r_flash;
              w_flash_cnt_next = '0;
            end else begin
              w_flash_cnt_next = r_flash_cnt + FLASH_W'(1);
            end
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register plus Moore outputs decoded from the next state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_lives     <= LIVES_W'(LIVES_INIT);
      r_frame_cnt <= '0;
      r_flash_cnt <= '0;
      r_flash     <= 1'b0;
      r_start_q   <= 1'b0;
      r_ball_hold <= 1'b1;
      r_ball_run  <= 1'b0;
      r_restore   <= 1'b0;
      r_clear     <= 1'b0;
      r_won       <= 1'b0;
      r_over      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_lives     <= w_lives_next;
      r_frame_cnt <= w_cnt_next;
      r_flash_cnt <= w_flash_cnt_next;
      r_flash     <= w_flash_next;
      r_start_q   <= i_start;
      r_ball_hold <= (w_state_next != ST_PLAY);
      r_ball_run  <= (w_state_next == ST_PLAY);
      r_restore   <= w_restore_next;
      r_clear     <= w_clear_next;
      r_won       <= (w_state_next == ST_WON);
      r_over      <= (w_state_next == ST_OVER);
    end
  end

  assign o_ball_hold      = r_ball_hold;
  assign o_ball_run       = r_ball_run;
  assign o_blocks_restore = r_restore;
  assign o_score_clear    = r_clear;
  assign o_lives          = r_lives;
  assign o_game_state     = r_state;
  assign o_flash          = r_flash;
  assign o_game_won       = r_won;
  assign o_game_over      = r_over;

endmodule

// File: tb/tb_game_controller.sv
// Scenario bench for game_controller with short serve/lost/flash timing.
module tb_game_controller;
  import breakout_pkg::*;

  localparam int unsigned NB = 10;

  logic          clock;
  logic          reset;
  logic          start;
  logic [9:0]    next_x;
  logic [9:0]    next_y;
  logic          ball_lost;
  logic [NB-1:0] block_exist;
  logic          ball_hold, ball_run, blocks_restore, score_clear;
  logic [1:0]    lives;
  logic [2:0]    game_state;
  logic          flash, game_won, game_over;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got, exp_v;

  game_controller #(
    .N_BLOCKS     (NB),
    .LIVES_INIT   (3),
    .SERVE_FRAMES (2),
    .LOST_FRAMES  (3),
    .FLASH_FRAMES (1),
    .V_ACTIVE     (480)
  ) dut (
    .i_clock          (clock),
    .i_reset          (reset),
    .i_start          (start),
    .i_next_x         (next_x),
    .i_next_y         (next_y),
    .i_ball_lost      (ball_lost),
    .i_block_exist    (block_exist),
    .o_ball_hold      (ball_hold),
    .o_ball_run       (ball_run),
    .o_blocks_restore (blocks_restore),
    .o_score_clear    (score_clear),
    .o_lives          (lives),
    .o_game_state     (game_state),
    .o_flash          (flash),
    .o_game_won       (game_won),
    .o_game_over      (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {state, lives, hold, run, flash, won, over, restore, clear}
  function automatic logic [11:0] mk(input game_state_t st, input logic [1:0] lv,
                                     input logic hold, input logic run, input logic fl,
                                     input logic won, input logic over,
                                     input logic rst, input logic clr);
    return {3'(st), lv, hold, run, fl, won, over, rst, clr};
  endfunction

  function automatic logic [11:0] observe();
    return {game_state, lives, ball_hold, ball_run, flash, game_won, game_over,
            blocks_restore, score_clear};
  endfunction

  // One frame: next_y sits on line 480 for a single cycle, then leaves it.
  task automatic frame();
    @(negedge clock);
    next_x = 10'($urandom_range(0, 799));
    next_y = 10'd480;
    @(negedge clock);
    next_y = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ball_lost = 1'b0; block_exist = '1;
    next_x = 10'd0; next_y = 10'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(mk(ST_IDLE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clock);
      got = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_errors++; $display("FAIL reset_idle[%0d]: got %h want %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    exp_q.push_back(mk(ST_SERVE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL start_pulse: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_SERVE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL start_pulse_end: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_SERVE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    frame();
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL serve_frame1: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_PLAY, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    frame();
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL serve_to_play: got %h want %h", got, exp_v); end
  endtask

  task automatic test_lose_life();
    logic [11:0] seq[5];
    seq[0] = mk(ST_LOST,  2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seq[1] = mk(ST_LOST,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seq[2] = mk(ST_SERVE, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seq[3] = mk(ST_SERVE, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seq[4] = mk(ST_PLAY,  2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ball_lost = 1'b1;
    exp_q.push_back(mk(ST_LOST, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    ball_lost = 1'b0;
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL lost_entry: got %h want %h", got, exp_v); end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(seq[i]);
      frame();
      got = observe(); exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_errors++; $display("FAIL lost_frame%0d: got %h want %h", i, got, exp_v); end
    end
  endtask

  // Level ball_lost held through LOST and SERVE: single decrement, then OVER after PLAY+1.
  task automatic test_game_over();
    ball_lost = 1'b1;
    exp_q.push_back(mk(ST_LOST, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL level_lost: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_SERVE, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) frame();
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL level_serve: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_PLAY, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) frame();
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL level_play: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_OVER, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL over_entry: got %h want %h", got, exp_v); end
    // Start is still held high from the first game: no further restart may happen.
    exp_q.push_back(mk(ST_OVER, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    repeat (5) @(negedge clock);
    ball_lost = 1'b0;
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL over_hold: got %h want %h", got, exp_v); end
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    exp_q.push_back(mk(ST_SERVE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL over_restart: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_PLAY, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) frame();
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL over_replay: got %h want %h", got, exp_v); end
  endtask

  task automatic test_won();
    block_exist = '0;
    ball_lost = 1'b1;
    exp_q.push_back(mk(ST_WON, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    ball_lost = 1'b0;
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL won_priority: got %h want %h", got, exp_v); end
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    exp_q.push_back(mk(ST_SERVE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL won_restart: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_PLAY, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) frame();
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL empty_play: got %h want %h", got, exp_v); end
    exp_q.push_back(mk(ST_WON, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL empty_won: got %h want %h", got, exp_v); end
    block_exist = '1;
  endtask

  task automatic test_reset_mid();
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    repeat (2) frame();
    ball_lost = 1'b1;
    @(negedge clock);
    ball_lost = 1'b0;
    repeat (5) frame();
    exp_q.push_back(mk(ST_PLAY, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL pre_reset_play: got %h want %h", got, exp_v); end
    reset = 1'b1;
    start = 1'b0;
    exp_q.push_back(mk(ST_IDLE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL reset_mid: got %h want %h", got, exp_v); end
    reset = 1'b0;
    exp_q.push_back(mk(ST_IDLE, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge clock);
    got = observe(); exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_errors++; $display("FAIL reset_release: got %h want %h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lose_life();
    test_game_over();
    test_won();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
